// File: rtl/alu_issue_arbiter.sv
// Two-port issue arbiter for the rv32i ALU stage: decode (port 0) has priority,
// the debug injector (port 1) is protected from starvation; flush drains the slot.
module alu_issue_arbiter #(
    parameter int unsigned PAYLOAD_W = 166,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req0_valid,
    output logic                 o_req0_ready,
    input  logic [PAYLOAD_W-1:0] i_req0_payload,
    input  logic                 i_req1_valid,
    output logic                 o_req1_ready,
    input  logic [PAYLOAD_W-1:0] i_req1_payload,
    output logic                 o_alu_ce,
    output logic [PAYLOAD_W-1:0] o_alu_payload,
    output logic                 o_alu_src,
    input  logic                 i_alu_stall,
    input  logic                 i_force_stall,
    input  logic                 i_flush,
    output logic                 o_stall,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_issue_cnt0,
    output logic [CNT_W-1:0]     o_issue_cnt1
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned FCNT_W = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;

    logic [1:0]           state_q,   state_d;
    logic                 alu_ce_q,  alu_ce_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 src_q,     src_d;
    logic [CNT_W-1:0]     cnt0_q,    cnt0_d;
    logic [CNT_W-1:0]     cnt1_q,    cnt1_d;
    logic [WAIT_W-1:0]    wait1_q,   wait1_d;
    logic [FCNT_W-1:0]    fcnt_q,    fcnt_d;

    logic consume;
    logic slot_free;
    logic win1;
    logic grant_ok;
    logic ready0;
    logic ready1;
    logic acc0;
    logic acc1;

    // Grant: the slot opens when empty or being drained this cycle; flush closes it.
    always_comb begin
        consume   = alu_ce_q && !i_alu_stall && !i_force_stall && !i_flush;
        slot_free = !alu_ce_q || consume;
        win1      = !i_req0_valid || (wait1_q == WAIT_W'(MAX_WAIT));
        grant_ok  = slot_free && !i_flush && (state_q != S_FLUSH) && !i_rst;
        ready0    = !win1 && grant_ok;
        ready1    = win1 && grant_ok;
        acc0      = i_req0_valid && ready0;
        acc1      = i_req1_valid && ready1;
    end

    always_comb begin
        state_d   = state_q;
        alu_ce_d  = alu_ce_q;
        payload_d = payload_q;
        src_d     = src_q;
        cnt0_d    = cnt0_q + CNT_W'(acc0);
        cnt1_d    = cnt1_q + CNT_W'(acc1);
        wait1_d   = wait1_q;
        fcnt_d    = fcnt_q;

        if (acc0 || acc1) begin
            alu_ce_d  = 1'b1;
            payload_d = acc1 ? i_req1_payload : i_req0_payload;
            src_d     = acc1;
        end else if (consume || i_flush) begin
            alu_ce_d = 1'b0;
        end

        // Starvation guard only accrues while port 1 is actually being refused.
        if ((state_q == S_FLUSH) || !i_req1_valid || acc1) begin
            wait1_d = '0;
        end else if (wait1_q != WAIT_W'(MAX_WAIT)) begin
            wait1_d = wait1_q + WAIT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_flush) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FCNT_W'(FLUSH_CYC);
                end else if (acc0 || acc1) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (i_flush) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FCNT_W'(FLUSH_CYC);
                end else if (consume && !acc0 && !acc1) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (i_flush) begin
                    fcnt_d = FCNT_W'(FLUSH_CYC);
                end else if (fcnt_q <= FCNT_W'(1)) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - FCNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            alu_ce_q  <= 1'b0;
            payload_q <= '0;
            src_q     <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            wait1_q   <= '0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            alu_ce_q  <= alu_ce_d;
            payload_q <= payload_d;
            src_q     <= src_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            wait1_q   <= wait1_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign o_req0_ready  = ready0;
    assign o_req1_ready  = ready1;
    assign o_stall       = i_req0_valid && !ready0;
    assign o_alu_ce      = alu_ce_q;
    assign o_alu_payload = payload_q;
    assign o_alu_src     = src_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_issue_cnt0  = cnt0_q;
    assign o_issue_cnt1  = cnt1_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a scoreboard of expected ALU presentations.
module tb_alu_issue_arbiter;

    localparam int unsigned PW = 166;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_req0_valid;
    logic          o_req0_ready;
    logic [PW-1:0] i_req0_payload;
    logic          i_req1_valid;
    logic          o_req1_ready;
    logic [PW-1:0] i_req1_payload;
    logic          o_alu_ce;
    logic [PW-1:0] o_alu_payload;
    logic          o_alu_src;
    logic          i_alu_stall;
    logic          i_force_stall;
    logic          i_flush;
    logic          o_stall;
    logic          o_busy;
    logic [CW-1:0] o_issue_cnt0;
    logic [CW-1:0] o_issue_cnt1;

    always #5 clk = ~clk;

    alu_issue_arbiter #(
        .PAYLOAD_W (PW),
        .MAX_WAIT  (4),
        .FLUSH_CYC (2),
        .CNT_W     (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_req0_valid   (i_req0_valid),
        .o_req0_ready   (o_req0_ready),
        .i_req0_payload (i_req0_payload),
        .i_req1_valid   (i_req1_valid),
        .o_req1_ready   (o_req1_ready),
        .i_req1_payload (i_req1_payload),
        .o_alu_ce       (o_alu_ce),
        .o_alu_payload  (o_alu_payload),
        .o_alu_src      (o_alu_src),
        .i_alu_stall    (i_alu_stall),
        .i_force_stall  (i_force_stall),
        .i_flush        (i_flush),
        .o_stall        (o_stall),
        .o_busy         (o_busy),
        .o_issue_cnt0   (o_issue_cnt0),
        .o_issue_cnt1   (o_issue_cnt1)
    );

    typedef struct packed {
        logic [PW-1:0] pl;
        logic          src;
    } exp_t;

    exp_t          sb_q[$];
    int unsigned   n_total  = 0;
    int unsigned   n_pass   = 0;
    logic [CW-1:0] ecnt0    = '0;
    logic [CW-1:0] ecnt1    = '0;
    logic [PW-1:0] last_pl  = '0;
    logic          last_src = 1'b0;
    logic [PW-1:0] pa;
    logic [PW-1:0] pb;

    function automatic logic [PW-1:0] rnd();
        return PW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: drive at negedge, check grant before the edge, check ALU side after it.
    task automatic cyc(input logic v0, input logic [PW-1:0] p0,
                       input logic v1, input logic [PW-1:0] p1,
                       input logic st, input logic fs, input logic fl,
                       input logic er0, input logic er1,
                       input logic ece, input logic ebusy);
        exp_t e;
        @(negedge clk);
        i_req0_valid   = v0;
        i_req0_payload = p0;
        i_req1_valid   = v1;
        i_req1_payload = p1;
        i_alu_stall    = st;
        i_force_stall  = fs;
        i_flush        = fl;
        #1;
        chk("ready0", PW'(o_req0_ready), PW'(er0));
        chk("ready1", PW'(o_req1_ready), PW'(er1));
        chk("stall",  PW'(o_stall),      PW'(v0 && !er0));
        if (v0 && er0) begin
            sb_q.push_back('{pl: p0, src: 1'b0});
            ecnt0++;
        end
        if (v1 && er1) begin
            sb_q.push_back('{pl: p1, src: 1'b1});
            ecnt1++;
        end
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e        = sb_q.pop_front();
            last_pl  = e.pl;
            last_src = e.src;
        end
        chk("alu_ce",  PW'(o_alu_ce),     PW'(ece));
        chk("payload", o_alu_payload,     last_pl);
        chk("src",     PW'(o_alu_src),    PW'(last_src));
        chk("cnt0",    PW'(o_issue_cnt0), PW'(ecnt0));
        chk("cnt1",    PW'(o_issue_cnt1), PW'(ecnt1));
        chk("busy",    PW'(o_busy),       PW'(ebusy));
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        i_rst          = 1'b1;
        i_req0_valid   = 1'b0;
        i_req0_payload = '0;
        i_req1_valid   = 1'b0;
        i_req1_payload = '0;
        i_alu_stall    = 1'b0;
        i_force_stall  = 1'b0;
        i_flush        = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ce",     PW'(o_alu_ce),     '0);
        chk("rst_pl",     o_alu_payload,     '0);
        chk("rst_cnt0",   PW'(o_issue_cnt0), '0);
        chk("rst_cnt1",   PW'(o_issue_cnt1), '0);
        chk("rst_busy",   PW'(o_busy),       '0);
        chk("rst_ready1", PW'(o_req1_ready), '0);
        i_rst = 1'b0;

        // Single decode op, one-cycle latency.
        cyc(1'b1, PW'(16'h1234), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();

        // Both ports valid: port 0 wins four times, then starvation guard grants port 1.
        pb = rnd();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, rnd(), 1'b1, pb, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, rnd(), 1'b1, pb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle();

        // ALU stall holds the presented op for three cycles.
        cyc(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        pa = rnd();
        repeat (3) cyc(1'b1, pa, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, pa, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();

        // Flush while active: op dropped, two blocked cycles, then accept again.
        cyc(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        pa = rnd();
        cyc(1'b1, pa, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, pa, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, pa, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, pa, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();

        // Flush with force_stall, then a second flush inside FLUSH reloads the count.
        cyc(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        pa = rnd();
        cyc(1'b1, pa, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, pa, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, pa, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, pa, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, pa, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, pa, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();

        // Drive both counters to all-ones, ending mid-ACTIVE.
        while (ecnt1 != '1)
            cyc(1'b0, '0, 1'b1, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        while (ecnt0 != '1)
            cyc(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset between edges clears everything at once.
        #2;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        i_rst        = 1'b1;
        #1;
        chk("arst_ce",     PW'(o_alu_ce),     '0);
        chk("arst_pl",     o_alu_payload,     '0);
        chk("arst_src",    PW'(o_alu_src),    '0);
        chk("arst_cnt0",   PW'(o_issue_cnt0), '0);
        chk("arst_cnt1",   PW'(o_issue_cnt1), '0);
        chk("arst_busy",   PW'(o_busy),       '0);
        chk("arst_ready0", PW'(o_req0_ready), '0);
        chk("arst_ready1", PW'(o_req1_ready), '0);
        chk("arst_stall",  PW'(o_stall),      '0);
        ecnt0    = '0;
        ecnt1    = '0;
        last_pl  = '0;
        last_src = 1'b0;
        sb_q.delete();
        @(negedge clk);
        i_rst = 1'b0;
        cyc(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Counter wrap without reset.
        while (ecnt0 != '1)
            cyc(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, rnd(), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Sequences and shares the rv32i ALU stage between two requesters.
  - Port 0: decode pipeline (primary).
  - Port 1: debug/test instruction injector (secondary).
- Arbitrates with port-0 priority and a starvation guard for port 1.
- Registers the winning operation bundle and drives the ALU stage clock enable.
- Honours ALU stall, debug stall and flush, and returns stall back to decode.

Parameters:
- PAYLOAD_W, 166, width of packed op bundle {alu, rs1_addr, rs1, rs2, imm, funct3, opcode, pc, rd_addr}; opaque to this block.
- MAX_WAIT, 4, cycles port 1 may be refused before it takes priority (1..15).
- FLUSH_CYC, 2, cycles both ports are held off after a flush (1..15).
- CNT_W, 16, width of per-port issue counters.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req0_valid  in  1  decode op valid.
- o_req0_ready  out  1  decode op accepted this cycle when valid.
- i_req0_payload  in  PAYLOAD_W  decode op bundle.
- i_req1_valid  in  1  debug op valid.
- o_req1_ready  out  1  debug op accepted this cycle when valid.
- i_req1_payload  in  PAYLOAD_W  debug op bundle.
- o_alu_ce  out  1  op presented to ALU (drives ALU i_ce).
- o_alu_payload  out  PAYLOAD_W  registered op bundle to ALU.
- o_alu_src  out  1  requester of presented op (0/1).
- i_alu_stall  in  1  ALU o_stall_from_alu.
- i_force_stall  in  1  debug stall.
- i_flush  in  1  pipeline flush.
- o_stall  out  1  stall to decode: i_req0_valid && !o_req0_ready.
- o_busy  out  1  state != IDLE.
- o_issue_cnt0  out  CNT_W  port-0 accepts, wraps.
- o_issue_cnt1  out  CNT_W  port-1 accepts, wraps.

Behaviour:
- Reset
  - All outputs and registers are 0; state IDLE; starvation counter 0.
  - Reset mid-operation discards the presented op immediately (async); no partial state survives.
- Consume condition
  - consume = o_alu_ce && !i_alu_stall && !i_force_stall && !i_flush.
  - slot_free = !o_alu_ce || consume.
- Grant
  - Default winner is port 0.
  - Port 1 wins when !i_req0_valid, or when wait1 == MAX_WAIT.
  - o_reqN_ready = (winner == N) && slot_free && !i_flush && state != FLUSH.
  - Ready is combinational; the loser's ready is 0.
- Accept
  - On valid && ready at an edge, the next cycle shows:
    - o_alu_ce = 1;
    - o_alu_payload = accepted payload;
    - o_alu_src = N;
    - o_issue_cntN += 1 (modulo 2^CNT_W).
  - Latency is 1 cycle request-to-ALU.
  - Back-to-back issue is allowed every cycle.
- Hold
  - If o_alu_ce = 1 and the op is not consumed (stall or force_stall), o_alu_ce, payload and src are held unchanged and both readys are 0.
  - If consumed with no new accept, o_alu_ce -> 0 and the payload holds its last value.
- Starvation
  - wait1 increments (saturating at MAX_WAIT) each cycle i_req1_valid && !o_req1_ready.
  - Clears on port-1 accept or when i_req1_valid = 0.
- State machine
  - IDLE (o_alu_ce = 0):
    - accept -> ACTIVE;
    - i_flush -> FLUSH.
  - ACTIVE (o_alu_ce = 1):
    - consume without accept -> IDLE;
    - consume with accept, or hold -> ACTIVE;
    - i_flush -> FLUSH.
  - FLUSH:
    - o_alu_ce = 0; readys = 0; wait1 = 0.
    - A down-counter loaded with FLUSH_CYC on entry; exits to IDLE when it reaches 0.
    - i_flush asserted while in FLUSH reloads the counter.
- Flush
  - Priority: i_flush beats accept, stall and force_stall in the same cycle.
  - The presented op is dropped (not consumed, not counted again).
  - Counters are not decremented.
- Simultaneous valids
  - Exactly one accept per cycle; never both readys = 1.

Test Plan:
- Reset, then req0 valid with payload 'h1234 and no stalls -> o_req0_ready = 1 in the same cycle; next cycle o_alu_ce = 1, o_alu_payload = 'h1234, o_alu_src = 0, o_issue_cnt0 = 1.
- req0 and req1 both valid continuously, MAX_WAIT = 4 -> port 0 wins 4 cycles, port 1 wins the 5th; issue counts 4 and 1; o_stall = 1 on the cycle port 1 wins.
- Op presented, i_alu_stall high for 3 cycles -> o_alu_ce/payload held 3 cycles; readys 0; o_stall = 1; accept resumes the cycle after stall drops.
- i_flush pulse for 1 cycle while ACTIVE with req0 valid -> no accept that cycle; o_alu_ce = 0 next cycle; readys 0 for FLUSH_CYC = 2 further cycles; then IDLE and req0 accepted.
- i_force_stall and i_flush together, plus a second flush pulse during FLUSH -> flush wins; FLUSH counter reloads, giving 2 cycles after the last flush.
- Assert i_rst asynchronously mid-ACTIVE with counters at 'hFFFF -> all outputs 0 immediately; after release, a port-0 accept gives o_issue_cnt0 = 1 (separate wrap check: 'hFFFF + 1 -> 0 without reset).
